// File: rtl/dr_word_decoder_pkg.sv
// Shared types for the dual-rail word decoder: error codes, FSM states and
// counter width.
package dr_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CONFLICT = 2'd1,
    ERR_OVERRUN  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/dr_word_decoder_bit_capture.sv
// One dual-rail bit: sticky p/n flops plus the merged view of this cycle's
// pulses, so the top can decide completion/conflict before anything is stored.
module dr_bit_capture
  import dr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic merge_en_i,
  input  logic clr_i,
  input  logic ld_i,
  input  logic in_p_i,
  input  logic in_n_i,
  output logic done_o,
  output logic conflict_o,
  output logic value_o
);

  logic p_q, n_q;
  logic p_d, n_d;

  // In FULL the inputs are ignored so the frozen word is what the top sees.
  assign p_d = p_q | (in_p_i & merge_en_i);
  assign n_d = n_q | (in_n_i & merge_en_i);

  assign done_o     = p_d | n_d;
  assign conflict_o = p_d & n_d;
  assign value_o    = p_d;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      p_q <= 1'b0;
      n_q <= 1'b0;
    end else if (ld_i) begin
      p_q <= p_d;
      n_q <= n_d;
    end
  end

endmodule

// File: rtl/dr_word_decoder.sv
// Dual-rail to single-rail word decoder with a 2-deep buffer (collection + output).
// Optional partial-word timeout is enabled by defining DR_DECODE_TIMEOUT_EN.
module dr_word_decoder
  import dr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_p,
  input  logic [WIDTH-1:0]     in_n,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q, err_d;
  err_code_t              err_code_q, err_code_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] bit_done, bit_conflict, bit_value;
  logic             merge_en, clr, ld;
  logic             any_conflict, all_done, any_set, any_in, out_free, tmo_hit;

  assign merge_en = (state_q != ST_FULL);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    dr_bit_capture u_cap (
      .clk        (clk),
      .rst_n      (rst_n),
      .merge_en_i (merge_en),
      .clr_i      (clr),
      .ld_i       (ld),
      .in_p_i     (in_p[gi]),
      .in_n_i     (in_n[gi]),
      .done_o     (bit_done[gi]),
      .conflict_o (bit_conflict[gi]),
      .value_o    (bit_value[gi])
    );
  end

  assign any_conflict = |bit_conflict;
  assign all_done     = &bit_done;
  assign any_set      = |bit_done;
  assign any_in       = |(in_p | in_n);
  assign out_free     = !out_valid_q || out_ready;

`ifdef DR_DECODE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle cycles in PARTIAL; any fresh pulse restarts the window.
  assign tmo_d   = (state_q != ST_PARTIAL || any_in) ? '0 : tmo_q + TMO_W'(1);
  assign tmo_hit = (state_q == ST_PARTIAL) && !any_in && (tmo_q == TMO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = 1'b0;
    err_code_d  = ERR_NONE;
    clr         = 1'b0;
    ld          = 1'b0;
    if (state_q == ST_FULL) begin
      if (any_in) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVERRUN;
      end
      if (out_valid_q && out_ready) begin
        out_data_d  = bit_value;
        out_valid_d = 1'b1;
        clr         = 1'b1;
        state_d     = ST_EMPTY;
      end
    end else if (any_conflict) begin
      err_d      = 1'b1;
      err_code_d = ERR_CONFLICT;
      clr        = 1'b1;
      state_d    = ST_EMPTY;
    end else if (all_done) begin
      if (out_free) begin
        out_data_d  = bit_value;
        out_valid_d = 1'b1;
        clr         = 1'b1;
        state_d     = ST_EMPTY;
      end else begin
        ld      = 1'b1;
        state_d = ST_FULL;
      end
    end else if (tmo_hit) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      clr        = 1'b1;
      state_d    = ST_EMPTY;
    end else begin
      ld      = 1'b1;
      state_d = any_set ? ST_PARTIAL : ST_EMPTY;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dr_word_decoder.sv
// Directed test-plan steps followed by random dual-rail traffic, all checked
// against a word-level reference model (WIDTH=4, TIMEOUT=16, timeout disabled).
module tb_dr_word_decoder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_p, in_n;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  logic [1:0]   err_code;
  logic [7:0]   err_cnt;

  dr_word_decoder #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_p      (in_p),
    .in_n      (in_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: rails seen so far, a parked complete word, the output slot.
  logic [W-1:0] m_seen_p, m_seen_n, m_parked, m_out;
  logic         m_has_parked, m_valid, m_err;
  int           m_code, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [W-1:0] p, input logic [W-1:0] n, input logic rdy,
                              input logic rst);
    logic [W-1:0] all_p, all_n;
    logic         taken;
    if (rst) begin
      m_seen_p = '0; m_seen_n = '0; m_parked = '0; m_out = '0;
      m_has_parked = 0; m_valid = 0; m_err = 0; m_code = 0; m_cnt = 0;
      return;
    end
    taken  = m_valid && rdy;
    m_err  = 0;
    m_code = 0;
    if (m_has_parked) begin
      if ((p | n) != 0) begin m_err = 1; m_code = 2; end
      if (taken) begin
        m_out = m_parked; m_valid = 1; m_has_parked = 0;
        m_seen_p = '0; m_seen_n = '0;
      end
    end else begin
      all_p = m_seen_p | p;
      all_n = m_seen_n | n;
      if (taken) m_valid = 0;
      if ((all_p & all_n) != 0) begin
        m_err = 1; m_code = 1; m_seen_p = '0; m_seen_n = '0;
      end else if ((all_p | all_n) == {W{1'b1}}) begin
        if (!m_valid) begin
          m_out = all_p; m_valid = 1; m_seen_p = '0; m_seen_n = '0;
        end else begin
          m_parked = all_p; m_has_parked = 1; m_seen_p = all_p; m_seen_n = all_n;
        end
      end else begin
        m_seen_p = all_p; m_seen_n = all_n;
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic step(input logic [W-1:0] p, input logic [W-1:0] n, input logic rdy,
                      input logic rst);
    in_p = p; in_n = n; out_ready = rdy; rst_n = !rst;
    @(posedge clk);
    model_update(p, n, rdy, rst);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_out));
    check("err",       32'(err),       32'(m_err));
    check("err_code",  32'(err_code),  m_code);
    check("err_cnt",   32'(err_cnt),   m_cnt);
  endtask

  initial begin
    logic [W-1:0] rp, rn;
    int           r;

    // Reset state
    step(4'h0, 4'h0, 1'b1, 1'b1);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_cnt",   32'(err_cnt),   32'd0);

    // 1: whole word in one cycle
    step(4'b1010, 4'b0101, 1'b1, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'hA);
    check("t1_err",   32'(err),       32'd0);

    // 2: split arrival, 1-cycle latency from the last pulse
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("t2_wait_valid", 32'(out_valid), 32'd0);
    step(4'b0000, 4'b1110, 1'b1, 1'b0);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data",  32'(out_data),  32'h1);

    // 3: conflict across cycles, then a clean word
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0100, 1'b1, 1'b0);
    check("t3_err",      32'(err),       32'd1);
    check("t3_code",     32'(err_code),  32'd1);
    check("t3_cnt",      32'(err_cnt),   32'd1);
    check("t3_no_valid", 32'(out_valid), 32'd0);
    step(4'b0011, 4'b1100, 1'b1, 1'b0);
    check("t3_data", 32'(out_data), 32'h3);

    // 4: backpressure fills both stages, extra pulse overruns
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0101, 4'b1010, 1'b0, 1'b0);
    step(4'b1100, 4'b0011, 1'b0, 1'b0);
    check("t4_hold", 32'(out_data), 32'h5);
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    check("t4_code", 32'(err_code), 32'd2);
    check("t4_keep", 32'(out_data), 32'h5);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("t4_second", 32'(out_data),  32'hC);
    check("t4_second_v", 32'(out_valid), 32'd1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("t4_drained", 32'(out_valid), 32'd0);

    // 5: without the timeout a partial word waits indefinitely
    step(4'b0011, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("t5_no_err", 32'(err), 32'd0);
    step(4'b0000, 4'b1100, 1'b1, 1'b0);
    check("t5_data", 32'(out_data), 32'h3);

    // 6: reset discards the partial word
    step(4'b0110, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    step(4'b0000, 4'b1001, 1'b1, 1'b0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_cnt",   32'(err_cnt),   32'd0);

    // Random traffic: mostly legal rails, occasional overlap, random backpressure
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      rp = W'($urandom);
      rn = W'($urandom);
      if (r < 3) begin rp = '0; rn = '0; end
      else if (r < 9) rn = rn & ~rp;
      step(rp, rn, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dr_word_decoder.md
Name: dr_word_decoder

Overview:
- Receiver end of the dual-rail datapath.
- Collects per-bit dual-rail pulses (logic 1 = pulse on `_p`, logic 0 = pulse on `_n`) from synthesized dual-rail logic into a complete WIDTH-bit word.
- Checks encoding legality and emits a single-rail binary word with a valid/ready handshake.
- Sits at the output boundary of a dual-rail netlist, feeding clocked single-rail consumers or the test harness.

Parameters:
- WIDTH, 8, number of dual-rail bits per word (1..32).
- TIMEOUT, 16, maximum cycles a partial word may stay incomplete; used only with the optional feature; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_p  input  WIDTH  positive-rail pulses; bit i high for one cycle means bit i = 1.
- in_n  input  WIDTH  negative-rail pulses; bit i high for one cycle means bit i = 0.
- out_data  output  WIDTH  decoded binary word.
- out_valid  output  1  out_data holds an undelivered word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- err  output  1  one-cycle error pulse.
- err_code  output  2  0 NONE, 1 CONFLICT, 2 OVERRUN, 3 TIMEOUT; valid when err=1, otherwise 0.
- err_cnt  output  8  saturating count of error events.

Behaviour:
- Interface: one clock clk; rst_n is synchronous, active-low.
- Reset: clears the collection registers col_p/col_n, out_data=0, out_valid=0, err=0, err_code=0, err_cnt=0, state=EMPTY.
  - A reset mid-word discards the partial word and any held output.
- Storage: collection stage (col_p, col_n, sticky per bit) and one output register. The two stages form a 2-deep buffer.
- Per-cycle merge (states EMPTY/PARTIAL): nxt_p = col_p | in_p; nxt_n = col_n | in_n.
- CONFLICT: any bit with nxt_p & nxt_n, whether both rails arrive the same cycle or on different cycles.
  - err=1, code 1.
  - Collection cleared next cycle; this cycle's inputs dropped; state -> EMPTY.
- Completion: &(nxt_p | nxt_n) and no conflict.
  - If the output register is free (out_valid=0, or out_valid & out_ready this cycle): out_data <= nxt_p, out_valid <= 1, collection cleared, state -> EMPTY. Latency is 1 cycle from the last rail pulse to out_valid.
  - Otherwise: collection frozen with nxt values, state -> FULL.
- Otherwise: collection updated. State -> PARTIAL if any bit is set, else EMPTY.
- FULL state:
  - Any nonzero in_p|in_n -> err=1, code 2 (OVERRUN). Pulses dropped; held word preserved.
  - When out_valid & out_ready: frozen word moves to out_data the next cycle (out_valid stays 1), collection cleared, state -> EMPTY.
  - Inputs arriving in the same cycle as the drain are still OVERRUN.
- Handshake: out_data is stable while out_valid=1 and out_ready=0. Back-to-back complete words sustain 1 word/cycle when out_ready=1.
- err_cnt: increments on every err pulse and saturates at 255.
- Error priority: at most one error per cycle, in the order OVERRUN > CONFLICT > TIMEOUT.

Optional Feature:
- Macro: DR_DECODE_TIMEOUT_EN.
- Defined:
  - Cycle counter resets on entry to PARTIAL and on any new rail pulse, and increments each cycle in PARTIAL.
  - On reaching TIMEOUT: err=1, code 3, collection cleared, state -> EMPTY.
  - A conflict in the same cycle reports CONFLICT only.
- Undefined: no counter is instantiated; PARTIAL persists indefinitely; code 3 never occurs.

Decomposition:
- Package dr_pkg:
  - err_code_t enum (ERR_NONE, ERR_CONFLICT, ERR_OVERRUN, ERR_TIMEOUT).
  - state_t enum (ST_EMPTY, ST_PARTIAL, ST_FULL).
  - ERR_CNT_W = 8.
- Sub-module dr_bit_capture: one instance per bit.
  - Holds the sticky p/n flops with a clear/freeze input.
  - Outputs done (p|n), conflict (p&n) and value (p).
- The top level reduces done/conflict across the instances and owns the FSM, output register, counters and timeout.

Test Plan (WIDTH=4, TIMEOUT=16):
1. in_p=4'b1010, in_n=4'b0101 in one cycle, out_ready=1 -> next cycle out_valid=1, out_data=4'hA; err=0.
2. Split arrival: cycle 0 in_p=4'b0001; cycle 3 in_n=4'b1110 -> out_valid rises at cycle 4 with out_data=4'h1; state PARTIAL during cycles 1-3.
3. Conflict: cycle 0 in_p=4'b0100; cycle 1 in_n=4'b0100 -> cycle 2 err=1, err_code=1, err_cnt=1; no out_valid; a following legal word 4'h3 decodes normally.
4. Backpressure/overrun: out_ready=0; send 4'h5 then 4'hC; then pulse in_p=4'b0001 -> err_code=2. Raise out_ready -> out_data 4'h5 then 4'hC on consecutive handshakes.
5. Timeout (macro defined): in_p=4'b0011, then idle -> after 16 cycles err=1, err_code=3, collection empty. Without the macro: no err, and completing later with in_n=4'b1100 yields out_data=4'h3.
6. Reset mid-word: in_p=4'b0110, then rst_n=0 for one cycle, then in_n=4'b1001 -> no out_valid (word incomplete), err_cnt=0.
